// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a direct mode and a prescaled
// auto-scan mode, used as a digit-select driver for multiplexed displays.
module scan_decoder #(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned DIV        = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      s,
  output logic [2**SEL_W-1:0]   out,
  output logic [SEL_W-1:0]      idx,
  output logic                  tick,
  output logic                  wrap
);

  localparam int unsigned NOUT = 2 ** SEL_W;
  // Prescaler must hold DIV-1; a DIV of 1 still gets a single bit.
  localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]   PRESC_MAX = PW'(DIV - 1);
  localparam logic [NOUT-1:0] INACTIVE  = ACTIVE_LOW ? {NOUT{1'b1}} : {NOUT{1'b0}};

  typedef enum logic [1:0] {
    StBlank,
    StDirect,
    StScan
  } state_e;

  state_e           r_state;
  logic [SEL_W-1:0] r_idx;
  logic [PW-1:0]    r_presc;
  logic [NOUT-1:0]  r_out;
  logic             r_tick;
  logic             r_wrap;

  logic [SEL_W-1:0] w_idx_inc;
  logic             w_term;

  // One-hot decode with the configured polarity.
  function automatic logic [NOUT-1:0] f_decode(input logic [SEL_W-1:0] i);
    logic [NOUT-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return ACTIVE_LOW ? ~v : v;
  endfunction

  assign w_idx_inc = r_idx + 1'b1;
  assign w_term    = (r_presc == PRESC_MAX);

  // Mode FSM with registered outputs; reset first, then blank, direct, scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StBlank;
      r_idx   <= '0;
      r_presc <= '0;
      r_out   <= INACTIVE;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (!en) begin
        // idx and prescaler freeze so a blanked display keeps its place.
        r_state <= StBlank;
        r_out   <= INACTIVE;
      end else if (!mode) begin
        r_state <= StDirect;
        r_idx   <= s;
        r_presc <= '0;
        r_out   <= f_decode(s);
      end else if (r_state != StScan) begin
        // Scan entry: reload the start index, restart the dwell, no tick.
        r_state <= StScan;
        r_idx   <= s;
        r_presc <= '0;
        r_out   <= f_decode(s);
      end else if (w_term) begin
        r_presc <= '0;
        r_idx   <= w_idx_inc;
        r_out   <= f_decode(w_idx_inc);
        r_tick  <= 1'b1;
        r_wrap  <= (r_idx == {SEL_W{1'b1}});
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign out  = r_out;
  assign idx  = r_idx;
  assign tick = r_tick;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: three instances cover the default
// configuration, inverted polarity, and a DIV=1 / SEL_W=3 build.
module tb_scan_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // u0: SEL_W=2, DIV=4, ACTIVE_LOW=1
  logic       a_en = 1'b0, a_mode = 1'b0;
  logic [1:0] a_s = '0;
  logic [3:0] a_out;
  logic [1:0] a_idx;
  logic       a_tick, a_wrap;

  // u1: SEL_W=2, DIV=4, ACTIVE_LOW=0
  logic       b_en = 1'b0, b_mode = 1'b0;
  logic [1:0] b_s = '0;
  logic [3:0] b_out;
  logic [1:0] b_idx;
  logic       b_tick, b_wrap;

  // u2: SEL_W=3, DIV=1, ACTIVE_LOW=1
  logic       c_en = 1'b0, c_mode = 1'b0;
  logic [2:0] c_s = '0;
  logic [7:0] c_out;
  logic [2:0] c_idx;
  logic       c_tick, c_wrap;

  scan_decoder #(.SEL_W(2), .DIV(4), .ACTIVE_LOW(1'b1)) u0 (
    .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .s(a_s),
    .out(a_out), .idx(a_idx), .tick(a_tick), .wrap(a_wrap)
  );

  scan_decoder #(.SEL_W(2), .DIV(4), .ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .s(b_s),
    .out(b_out), .idx(b_idx), .tick(b_tick), .wrap(b_wrap)
  );

  scan_decoder #(.SEL_W(3), .DIV(1), .ACTIVE_LOW(1'b1)) u2 (
    .clk(clk), .rst(rst), .en(c_en), .mode(c_mode), .s(c_s),
    .out(c_out), .idx(c_idx), .tick(c_tick), .wrap(c_wrap)
  );

  // Hand-computed active-low decode of a 2-bit index.
  logic [3:0] al_tab [4];
  logic [3:0] ah_tab [4];
  initial begin
    al_tab[0] = 4'b1110; al_tab[1] = 4'b1101; al_tab[2] = 4'b1011; al_tab[3] = 4'b0111;
    ah_tab[0] = 4'b0001; ah_tab[1] = 4'b0010; ah_tab[2] = 4'b0100; ah_tab[3] = 4'b1000;
  end

  // At most one line active on every instance, every cycle.
  always @(negedge clk) begin
    if (!$isunknown(a_out) && !$isunknown(b_out) && !$isunknown(c_out)) begin
      n_cmp++;
      if (!$onehot0(~a_out) || !$onehot0(b_out) || !$onehot0(~c_out)) begin
        n_err++;
        $display("FAIL onehot0: a=%b b=%b c=%b (required at most one active)",
                 a_out, b_out, c_out);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Check u0 against expected out/idx/tick/wrap.
  task automatic chk_a(input string nm, input logic [3:0] eo, input logic [1:0] ei,
                       input logic et, input logic ew);
    n_cmp++;
    if (a_out !== eo || a_idx !== ei || a_tick !== et || a_wrap !== ew) begin
      n_err++;
      $display("FAIL %s: out=%b idx=%0d tick=%b wrap=%b, required out=%b idx=%0d tick=%b wrap=%b",
               nm, a_out, a_idx, a_tick, a_wrap, eo, ei, et, ew);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    chk_a("reset_u0", 4'b1111, 2'd0, 1'b0, 1'b0);
    n_cmp++;
    if (b_out !== 4'b0000 || b_idx !== 2'd0 || b_tick !== 1'b0 || b_wrap !== 1'b0) begin
      n_err++;
      $display("FAIL reset_u1: out=%b idx=%0d tick=%b wrap=%b, required 0000/0/0/0",
               b_out, b_idx, b_tick, b_wrap);
    end
    n_cmp++;
    if (c_out !== 8'hFF || c_idx !== 3'd0 || c_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_u2: out=%b idx=%0d tick=%b, required 11111111/0/0",
               c_out, c_idx, c_tick);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk_a("blank_after_reset", 4'b1111, 2'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_direct();
    a_en = 1'b1; a_mode = 1'b0;
    b_en = 1'b1; b_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_s = 2'(i);
      b_s = 2'(i);
      cyc();
      chk_a("direct_al", al_tab[i], 2'(i), 1'b0, 1'b0);
      n_cmp++;
      if (b_out !== ah_tab[i] || b_idx !== 2'(i)) begin
        n_err++;
        $display("FAIL direct_ah: out=%b idx=%0d, required out=%b idx=%0d",
                 b_out, b_idx, ah_tab[i], i);
      end
    end
  endtask

  // Scan from s=2 until idx=1 with prescaler=2 (15 edges including entry).
  task automatic test_scan();
    logic [1:0] ei;
    a_s = 2'd2; a_mode = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      cyc();
      if (c == 5) a_s = 2'd0;  // ignored while scanning
      ei = 2'((2 + c / 4) % 4);
      chk_a("scan", al_tab[ei], ei, (c > 0 && c % 4 == 0), (c == 8));
    end
  endtask

  task automatic test_blank_resume();
    a_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_a("blank_hold", 4'b1111, 2'd1, 1'b0, 1'b0);
    end
    a_en = 1'b1; a_mode = 1'b1; a_s = 2'd0;
    cyc();
    chk_a("resume_entry", 4'b1110, 2'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      chk_a("resume_dwell", 4'b1110, 2'd0, 1'b0, 1'b0);
    end
    cyc();
    chk_a("resume_step", 4'b1101, 2'd1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Scan -> direct -> scan re-entry restarts the dwell from zero.
    a_mode = 1'b0; a_s = 2'd3;
    cyc();
    chk_a("scan_to_direct", 4'b0111, 2'd3, 1'b0, 1'b0);
    a_mode = 1'b1; a_s = 2'd2;
    for (int c = 0; c <= 3; c++) begin
      cyc();
      chk_a("reentry_dwell", 4'b1011, 2'd2, 1'b0, 1'b0);
    end
    // Now at terminal count: en fall on that edge wins, idx unchanged.
    a_en = 1'b0;
    cyc();
    chk_a("blank_vs_term", 4'b1111, 2'd2, 1'b0, 1'b0);
    // Re-enter and reach terminal count again, then reset on that edge.
    a_en = 1'b1;
    for (int c = 0; c <= 3; c++) cyc();
    chk_a("pre_reset_term", 4'b1011, 2'd2, 1'b0, 1'b0);
    rst = 1'b1;
    cyc();
    chk_a("reset_vs_term", 4'b1111, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_div1();
    c_en = 1'b1; c_mode = 1'b1; c_s = 3'd0;
    cyc();
    n_cmp++;
    if (c_out !== 8'b1111_1110 || c_idx !== 3'd0 || c_tick !== 1'b0) begin
      n_err++;
      $display("FAIL div1_entry: out=%b idx=%0d tick=%b, required 11111110/0/0",
               c_out, c_idx, c_tick);
    end
    for (int c = 1; c <= 16; c++) begin
      cyc();
      n_cmp++;
      if (c_idx !== 3'(c % 8) || c_tick !== 1'b1 || c_wrap !== (c % 8 == 0) ||
          c_out !== ~(8'd1 << (c % 8))) begin
        n_err++;
        $display("FAIL div1_step%0d: idx=%0d tick=%b wrap=%b out=%b, required idx=%0d tick=1 wrap=%b",
                 c, c_idx, c_tick, c_wrap, c_out, c % 8, (c % 8 == 0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_direct();
    test_scan();
    test_blank_resume();
    test_back_to_back();
    test_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Registered, parametrised N-to-2^N decoder with active-low (or active-high) one-hot outputs.
- Two modes:
  - Direct: decodes the select input.
  - Scan: a free-running, prescaled index walks through all outputs. Used as the digit-select driver for multiplexed 7-segment displays.
- Sits between the control logic and the display or other enable-line fan-out.

Parameters:
- SEL_W, 2, width of the select/index; the block drives 2**SEL_W outputs.
- DIV, 4, clock cycles per scan step; legal range 1..65535.
- ACTIVE_LOW, 1, 1 = selected output driven 0 and others 1; 0 = inverted polarity.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  1 = outputs active; 0 = blank (all outputs inactive).
- mode  input  1  0 = direct decode of s; 1 = auto-scan.
- s  input  SEL_W  select value in direct mode; start index on scan entry.
- out  output  2**SEL_W  one-hot enable lines (polarity per ACTIVE_LOW), registered.
- idx  output  SEL_W  index currently decoded onto out, registered.
- tick  output  1  one-cycle pulse in the cycle idx advances in scan mode.
- wrap  output  1  one-cycle pulse coincident with tick when idx goes from 2**SEL_W-1 to 0.

Behaviour:
- Reset (rst=1 at an edge):
  - out = all inactive (all 1s if ACTIVE_LOW=1, all 0s otherwise).
  - idx=0, tick=0, wrap=0, prescaler=0, FSM=BLANK.
  - Reset has priority over all other inputs.
  - A reset mid-scan aborts the step with no tick.
- FSM states: BLANK, DIRECT, SCAN. Next-state is evaluated each edge:
  - en=0 -> BLANK.
  - en=1, mode=0 -> DIRECT.
  - en=1, mode=1 -> SCAN.
- BLANK:
  - out is all inactive.
  - idx, prescaler and tick/wrap hold their values (tick/wrap = 0).
- DIRECT:
  - idx <= s each cycle.
  - out is the one-hot decode of the new idx.
  - Latency: s to out is 1 clock.
  - The prescaler is held at 0.
- SCAN entry (previous state not SCAN, or first cycle after reset with mode=1):
  - idx <= s, prescaler <= 0, no tick.
  - out shows s on the next cycle.
- SCAN steady state:
  - The prescaler counts 0..DIV-1.
  - On the cycle the prescaler equals DIV-1: prescaler <= 0, idx <= idx+1 mod 2**SEL_W, tick=1.
  - wrap=1 additionally if the old idx was all-ones.
  - Each index is displayed for exactly DIV cycles.
  - DIV=1: idx advances every cycle and tick is held high.
- Leaving SCAN:
  - Switching to DIRECT takes effect next edge; the prescaler is cleared.
  - Switching to BLANK freezes idx and the prescaler; re-enable with mode=1 counts as scan entry (reloads s).
- out integrity:
  - At most one line is active on any cycle, never more.
  - Exactly one line is active in DIRECT/SCAN; none in BLANK or reset.
  - out is driven only from registers, so it is glitch-free.
- s changes while in SCAN are ignored.
- Simultaneous en fall and a prescaler terminal count: BLANK wins, no tick, idx unchanged.
- Widths:
  - The prescaler is sized to hold DIV-1, minimum 1 bit.
  - idx increments modulo 2**SEL_W with no overflow flag other than wrap.

Test Plan:
- Reset: SEL_W=2, ACTIVE_LOW=1, rst=1 for 2 cycles -> out=4'b1111, idx=0, tick=0, wrap=0; hold en=0 after release -> out stays 4'b1111.
- Direct decode: en=1, mode=0, s=0,1,2,3 on successive cycles -> out=1110, 1101, 1011, 0111, each one clock after s; idx tracks s. With ACTIVE_LOW=0: out=0001, 0010, 0100, 1000.
- Scan: DIV=4, s=2, en=1, mode=1 -> idx=2 for 4 cycles, then 3, 0, 1, 2; tick pulses every 4th cycle; wrap pulses only on the 3->0 step; out=1011, 0111, 1110, 1101.
- Blank/resume: during scan at idx=1 with prescaler=2, drop en for 3 cycles -> out=1111, idx holds 1, no tick; raise en with mode=1, s=0 -> idx reloads 0, full 4-cycle dwell.
- Edge cases:
  - DIV=1, SEL_W=3 -> idx advances every cycle 0..7, tick constant 1, wrap once per 8 cycles.
  - rst asserted in the same cycle as a terminal count -> idx=0, tick=0.
  - Assertion checked throughout: at most one out line active.
